// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/MDU: operation codes, control FSM states
// and a helper that classifies an opcode as multiply/divide.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1010;
   localparam logic [3:0] ALU_DIVU  = 4'b1011;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FIX,
      ST_DONE
   } state_e;

   // Codes 10xx are the iterative multiply/divide group.
   // Within that group bit 1 selects divide and bit 0 selects unsigned.
   function automatic logic is_muldiv(input logic [3:0] ctr);
      return ctr[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide core. Operands are reduced to magnitudes on start.
// A single shared WIDTH+1 adder is used for both the shift-add multiply and the restoring divide.
// The unit needs WIDTH iterations to produce a result.
// Sign correction of the product, quotient and remainder is combinational on the held magnitudes.
// hi and lo are valid from the cycle after done until the next start.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,      // [1]=divide, [0]=unsigned
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,    // high during the final iteration
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // product high / partial remainder
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend-quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand / divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;         // product / quotient negative
   logic             rneg_q, rneg_d;       // remainder negative (dividend sign)
   logic             dz_q, dz_d;           // divisor was zero

   logic             sa, sb;
   logic [WIDTH-1:0] ma, mb;
   logic [WIDTH:0]   add_a, add_b;
   logic             add_c;
   logic [WIDTH+1:0] sum_full;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign sa = !op[0] && a[WIDTH-1];
   assign sb = !op[0] && b[WIDTH-1];
   assign ma = sa ? -a : a;
   assign mb = sb ? -b : b;

   // Shared adder: multiply accumulates, divide trial-subtracts (carry out = no borrow).
   always_comb begin
      add_a = div_q ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
      add_b = '0;
      if (div_q) begin
         add_b = ~{1'b0, opnd_q};
      end else if (acc_lo_q[0]) begin
         add_b = {1'b0, opnd_q};
      end
      add_c    = div_q;
      sum_full = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_c);
   end

   // Load on start, then one quotient/product bit per cycle.
   always_comb begin
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      div_d    = div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      if (start) begin
         acc_hi_d = '0;
         acc_lo_d = ma;
         opnd_d   = mb;
         cnt_d    = '0;
         run_d    = 1'b1;
         div_d    = op[1];
         neg_d    = sa ^ sb;
         rneg_d   = sa;
         dz_d     = (b == '0);
      end else if (run_q) begin
         if (div_q) begin
            acc_hi_d = sum_full[WIDTH+1] ? sum_full[WIDTH-1:0] : add_a[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], sum_full[WIDTH+1]};
         end else begin
            acc_hi_d = sum_full[WIDTH:1];
            acc_lo_d = {sum_full[0], acc_lo_q[WIDTH-1:1]};
         end
         if (cnt_q == CNT_W'(WIDTH-1)) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Iteration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
      end
   end

   assign done = run_q && (cnt_q == CNT_W'(WIDTH-1));

   // Sign fix-up. A zero divisor forces an all-ones quotient.
   // The remainder then naturally equals the dividend.
   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
      rem_fix  = rneg_q ? -acc_hi_q : acc_hi_q;
      hi       = prod_fix[2*WIDTH-1:WIDTH];
      lo       = prod_fix[WIDTH-1:0];
      if (div_q) begin
         hi = rem_fix;
         lo = dz_q ? '1 : quo_fix;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with valid/ready handshakes.
// Single-cycle ops register their result on the accept edge.
// mul/div ops run through mdu_iter (BUSY), take one fix-up cycle (FIX), and then present the result while still blocking new input (DONE).
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CTR_W-1:0] aluCtr,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] aluRes,
   output logic             zero,
   output logic             ovf,
   output logic             err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;
   logic             mul_q, mul_d;

   logic             fire;
   logic             mdu_start, mdu_done;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;
   logic [WIDTH-1:0] sum_w, diff_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf, alu_err;

   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign fire      = in_valid && in_ready;
   assign mdu_start = fire && is_muldiv(aluCtr);
   assign sum_w     = input1 + input2;
   assign diff_w    = input1 - input2;

   mdu_iter #(
      .WIDTH (WIDTH)
   ) u_mdu (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdu_start),
      .op    (aluCtr[1:0]),
      .a     (input1),
      .b     (input2),
      .done  (mdu_done),
      .hi    (mdu_hi),
      .lo    (mdu_lo)
   );

   // Single-cycle result and flags for the non-iterative opcodes.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_err = 1'b0;
      case (aluCtr)
         ALU_ADD: begin
            alu_res = sum_w;
            alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum_w[WIDTH-1] != input1[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = diff_w;
            alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff_w[WIDTH-1] != input1[WIDTH-1]);
         end
         ALU_AND:  alu_res = input1 & input2;
         ALU_OR:   alu_res = input1 | input2;
         ALU_XOR:  alu_res = input1 ^ input2;
         ALU_NOR:  alu_res = ~(input1 | input2);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
         ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: begin
            alu_res = '0;
         end
         default:  alu_err = 1'b1;
      endcase
   end

   // Control FSM next state, handshake and output register updates.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      dz_d        = dz_q;
      mul_d       = mul_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               if (is_muldiv(aluCtr)) begin
                  state_d = ST_BUSY;
                  dz_d    = aluCtr[1] && (input2 == '0);
                  mul_d   = !aluCtr[1];
               end else begin
                  out_valid_d = 1'b1;
                  res_d       = alu_res;
                  zero_d      = (alu_res == '0);
                  ovf_d       = alu_ovf;
                  err_d       = alu_err;
               end
            end
         end
         ST_BUSY: begin
            if (mdu_done) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            out_valid_d = 1'b1;
            hi_d        = mdu_hi;
            lo_d        = mdu_lo;
            res_d       = mdu_lo;
            zero_d      = mul_q ? ({mdu_hi, mdu_lo} == '0) : (mdu_lo == '0);
            ovf_d       = 1'b0;
            err_d       = dz_q;
            state_d     = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         dz_q        <= 1'b0;
         mul_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         dz_q        <= dz_d;
         mul_q       <= mul_d;
      end
   end

   assign out_valid = out_valid_q;
   assign aluRes    = res_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign err       = err_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32): hand-computed vectors, immediate assertions.
module tb_alu_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  aluCtr;
   logic [31:0] input1, input2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] aluRes;
   logic        zero, ovf, err;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;
   int lat, low;

   alu_mdu #(.WIDTH(32), .CTR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluCtr    (aluCtr),
      .input1    (input1),
      .input2    (input2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .aluRes    (aluRes),
      .zero      (zero),
      .ovf       (ovf),
      .err       (err),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, then wait (bounded) for its result; counts cycles with in_ready low.
   task automatic do_op(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                        output int lat_o, output int low_o);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk("issue_ready", {63'd0, in_ready}, 64'd1);
      aluCtr = ctr; input1 = a; input2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat_o = 1;
      low_o = in_ready ? 0 : 1;
      while (!out_valid && lat_o < 100) begin
         @(posedge clk); #1;
         lat_o++;
         if (!in_ready) low_o++;
      end
   endtask

   task automatic op_chk(input string tag, input logic [3:0] ctr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_res, input logic [2:0] e_flg,
                         input int e_lat);
      int l, lw;
      do_op(ctr, a, b, l, lw);
      lat = l;
      low = lw;
      $display("op %s ctr=%b a=%h b=%h -> res=%h zero=%b ovf=%b err=%b hi=%h lo=%h lat=%0d",
               tag, ctr, a, b, aluRes, zero, ovf, err, hi, lo, l);
      chk({tag, "_lat"}, 64'(l), 64'(e_lat));
      chk({tag, "_res"}, {32'd0, aluRes}, {32'd0, e_res});
      chk({tag, "_flg"}, {61'd0, zero, ovf, err}, {61'd0, e_flg});
   endtask

   task automatic hilo_chk(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
      chk({tag, "_hilo"}, {hi, lo}, {e_hi, e_lo});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      aluCtr = 4'b0000; input1 = '0; input2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", {60'd0, out_valid, zero, ovf, err}, 64'd0);
      chk("rst_res", {32'd0, aluRes}, 64'd0);
      hilo_chk("rst", 32'h0, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // single-cycle ops: flags are {zero,ovf,err}
      op_chk("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b010, 1);
      chk("add_low", 64'(low), 64'd0);
      op_chk("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 3'b100, 1);
      op_chk("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 3'b010, 1);
      op_chk("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 3'b000, 1);
      op_chk("sltu", 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b100, 1);
      op_chk("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 3'b000, 1);
      op_chk("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 3'b000, 1);
      op_chk("xor", 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 3'b000, 1);
      op_chk("nor", 4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 3'b000, 1);
      op_chk("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b100, 1);

      // multiply / divide
      op_chk("mult", 4'b1000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 3'b000, 34);
      chk("mult_low", 64'(low), 64'd34);
      hilo_chk("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
      op_chk("add_after", 4'b0010, 32'h1, 32'h1, 32'h2, 3'b000, 1);
      hilo_chk("add_keep", 32'hFFFFFFFF, 32'hFFFFFFFE);
      op_chk("multu", 4'b1001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 3'b000, 34);
      hilo_chk("multu", 32'h1, 32'hFFFFFFFE);
      op_chk("mult_z", 4'b1000, 32'h0, 32'h5, 32'h0, 3'b100, 34);
      hilo_chk("mult_z", 32'h0, 32'h0);
      op_chk("mult_min", 4'b1000, 32'h80000000, 32'h80000000, 32'h0, 3'b000, 34);
      hilo_chk("mult_min", 32'h40000000, 32'h0);
      op_chk("div_neg", 4'b1010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 3'b000, 34);
      hilo_chk("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
      op_chk("divu_z", 4'b1011, 32'h7, 32'h0, 32'hFFFFFFFF, 3'b001, 34);
      hilo_chk("divu_z", 32'h7, 32'hFFFFFFFF);
      op_chk("div_z", 4'b1010, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF, 3'b001, 34);
      hilo_chk("div_z", 32'hFFFFFFF8, 32'hFFFFFFFF);
      op_chk("div_min", 4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b000, 34);
      hilo_chk("div_min", 32'h0, 32'h80000000);
      op_chk("divu", 4'b1011, 32'd100, 32'd7, 32'd14, 3'b000, 34);
      hilo_chk("divu", 32'd2, 32'd14);
      op_chk("div_nb", 4'b1010, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 3'b000, 34);
      hilo_chk("div_nb", 32'h1, 32'hFFFFFFFD);
      op_chk("divu_q0", 4'b1011, 32'd3, 32'd5, 32'h0, 3'b100, 34);
      hilo_chk("divu_q0", 32'd3, 32'h0);

      // backpressure: result held, new request ignored while stalled
      op_chk("bp_add", 4'b0010, 32'd3, 32'd4, 32'd7, 3'b000, 1);
      out_ready = 1'b0;
      aluCtr = 4'b0110; input1 = 32'd100; input2 = 32'd1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         $display("stall cycle %0d: out_valid=%b res=%h in_ready=%b", k, out_valid, aluRes, in_ready);
         chk("bp_hold", {in_ready, out_valid, aluRes}, {1'b0, 1'b1, 32'd7});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      $display("drain+fire: out_valid=%b res=%h", out_valid, aluRes);
      chk("bp_refire", {out_valid, aluRes}, {1'b1, 32'd99});

      // full-rate back-to-back adds
      for (int i = 1; i <= 4; i++) begin
         chk("b2b_ready", {63'd0, in_ready}, 64'd1);
         aluCtr = 4'b0010; input1 = 32'(i); input2 = 32'(i);
         @(posedge clk); #1;
         $display("b2b %0d: out_valid=%b res=%h", i, out_valid, aluRes);
         chk("b2b_res", {out_valid, aluRes}, {1'b1, 32'(2 * i)});
      end
      in_valid = 1'b0;

      // reset in the middle of a divide
      aluCtr = 4'b1011; input1 = 32'd100; input2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid_busy", {63'd0, in_ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      $display("mid-divide reset: out_valid=%b res=%h hi=%h lo=%h", out_valid, aluRes, hi, lo);
      chk("mid_rst_flags", {60'd0, out_valid, zero, ovf, err}, 64'd0);
      chk("mid_rst_res", {32'd0, aluRes}, 64'd0);
      hilo_chk("mid_rst", 32'h0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_ready", {63'd0, in_ready}, 64'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("mid_no_result", {63'd0, out_valid}, 64'd0);

      // illegal codes leave hi/lo untouched
      op_chk("multu2", 4'b1001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 3'b000, 34);
      hilo_chk("multu2", 32'h1, 32'hFFFFFFFE);
      op_chk("ill_1111", 4'b1111, 32'h12345678, 32'h1, 32'h0, 3'b101, 1);
      hilo_chk("ill_1111", 32'h1, 32'hFFFFFFFE);
      op_chk("ill_0101", 4'b0101, 32'h5, 32'h6, 32'h0, 3'b101, 1);
      op_chk("add_post", 4'b0010, 32'd10, 32'd20, 32'd30, 3'b000, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
